mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the pipelined datapath's instruction-fetch port and data-access port onto a single physical memory port. Sits directly downstream of the datapath's `instr_mem_*` / `data_mem_*` interface and upstream of the shared memory (or future unified cache). It latches one request at a time, drives it to memory, and routes the `pmem_resp` handshake back to the requesting port only. This lets the datapath move from dual magic memories to a single-ported memory without changing its port list.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width of all ports
- `DATA_WIDTH`, 32, data width of all ports; byte-enable width is `DATA_WIDTH/8`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset)
- `instr_mem_read`  in  1  fetch request; held until `instr_mem_resp`
- `instr_mem_address`  in  ADDR_WIDTH  fetch address
- `instr_mem_rdata`  out  DATA_WIDTH  fetch data, valid when `instr_mem_resp`=1
- `instr_mem_resp`  out  1  one-cycle completion pulse for fetch
- `data_mem_read`  in  1  load request; held until `data_mem_resp`
- `data_mem_write`  in  1  store request; held until `data_mem_resp`
- `data_mem_address`  in  ADDR_WIDTH  load/store address
- `data_mem_wdata`  in  DATA_WIDTH  store data
- `mem_byte_enable`  in  DATA_WIDTH/8  store byte mask
- `data_mem_rdata`  out  DATA_WIDTH  load data, valid when `data_mem_resp`=1
- `data_mem_resp`  out  1  one-cycle completion pulse for load/store
- `pmem_read` / `pmem_write`  out  1  physical memory strobes, registered
- `pmem_address`  out  ADDR_WIDTH  registered
- `pmem_wdata`  out  DATA_WIDTH  registered
- `pmem_byte_enable`  out  DATA_WIDTH/8  registered
- `pmem_rdata`  in  DATA_WIDTH  memory read data
- `pmem_resp`  in  1  memory completion pulse

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`. Reset state `IDLE`.
- `IDLE`: if a data request (`data_mem_read|data_mem_write`) is pending, grant data and go to `SERVE_D`. Else, if `instr_mem_read` is pending, grant fetch and go to `SERVE_I`. Else stay.
- On grant, latch address, wdata, byte enable and read/write into the pmem output registers.
  - Fetch: `pmem_byte_enable` = all ones, `pmem_wdata` = 0.
- `SERVE_x`: strobes held constant until `pmem_resp`=1.
  - In that cycle, the granted port's resp = 1 and its rdata = `pmem_rdata`. The other port's resp stays 0.
  - Next edge: strobes clear, state returns to `IDLE`.
- `instr_mem_rdata` and `data_mem_rdata` are always a combinational copy of `pmem_rdata`; consumers qualify them with resp.
- Requester dropping its request mid-transaction: the transaction still completes and resp still pulses. The arbiter never aborts a memory access.
- `data_mem_read` and `data_mem_write` both high: treated as a write. A simulation assertion flags it.
- Reset asserted mid-transaction: state returns to `IDLE` and all strobes and resps drop immediately (asynchronous). Any in-flight `pmem_resp` is ignored.
- Reset values: `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `pmem_byte_enable`=0, `instr_mem_resp`=0, `data_mem_resp`=0.

## Timing
- Request sampled in `IDLE` at edge N; pmem strobes high from cycle N+1.
- `pmem_resp` in cycle M gives requester resp in cycle M (zero added latency on return). Strobes are low in M+1.
- Back-to-back: `IDLE` occupies cycle M+1, so the next grant's strobes rise at M+2. This is one bubble per access, which is required.
- A memory with 1-cycle response gives a 3-cycle request-to-resp latency per access.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. A `last_grant` flop (reset to instruction) records the last port served. On simultaneous requests in `IDLE`, the port not served last wins. A single request is granted regardless.
- Undefined: fixed priority, data always wins, no `last_grant` flop. Fetch starvation is excluded because the datapath stalls on an outstanding data access.

## Structure
- Shared package `mem_arb_types`:
  - `typedef enum arb_state_t {IDLE, SERVE_I, SERVE_D}`
  - `typedef enum arb_grant_t {GRANT_I, GRANT_D}`
- One sub-module, `mem_arb_req_reg`: the load-enabled, async-reset register bank holding address, wdata, byte enable, read and write. The top holds the FSM, the arbitration logic and the resp routing.

## Test plan
- Fetch only: `instr_mem_read`=1, addr 0x60, memory responds 1 cycle after strobe with 0x00000013 -> `pmem_read` high cycle 1; `instr_mem_resp`=1 with rdata 0x00000013 in cycle 2; `data_mem_resp` never 1.
- Simultaneous fetch 0x64 and store 0x1000 (wdata 0xDEADBEEF, be 0b0011), fixed priority -> store issued first with `pmem_write`=1 and be 0b0011; fetch strobes rise exactly 2 cycles after the store's resp.
- Same as previous with `MEM_ARB_RR_EN` and `last_grant`=data -> fetch served first, then store.
- Memory with 5-cycle response, request dropped after 1 cycle -> strobes and address held stable for all 5 cycles; resp still pulses once.
- `rst` driven low mid-`SERVE_D`, off-edge -> `pmem_write` and resps drop before the next clock edge; after release, state is `IDLE` and a new fetch is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_types: shared FSM state and grant encodings for mem_arbiter
package mem_arb_types;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;
endpackage

// File: rtl/mem_arb_req_reg.sv
// mem_arb_req_reg: latched physical-memory request (address, data, mask, strobes)
module mem_arb_req_reg #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clr,
  input  logic [ADDR_WIDTH-1:0]   address_d,
  input  logic [DATA_WIDTH-1:0]   wdata_d,
  input  logic [DATA_WIDTH/8-1:0] byte_enable_d,
  input  logic                    read_d,
  input  logic                    write_d,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] byte_enable,
  output logic                    read,
  output logic                    write
);
  // capture a granted request; only the strobes drop when the access completes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      address     <= '0;
      wdata       <= '0;
      byte_enable <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
    end else if (load) begin
      address     <= address_d;
      wdata       <= wdata_d;
      byte_enable <= byte_enable_d;
      read        <= read_d;
      write       <= write_d;
    end else if (clr) begin
      read        <= 1'b0;
      write       <= 1'b0;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pmem port between fetch and data ports (MEM_ARB_RR_EN selects round-robin)
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_mem_read,
  input  logic [ADDR_WIDTH-1:0]   instr_mem_address,
  output logic [DATA_WIDTH-1:0]   instr_mem_rdata,
  output logic                    instr_mem_resp,
  input  logic                    data_mem_read,
  input  logic                    data_mem_write,
  input  logic [ADDR_WIDTH-1:0]   data_mem_address,
  input  logic [DATA_WIDTH-1:0]   data_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   data_mem_rdata,
  output logic                    data_mem_resp,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  output logic [DATA_WIDTH/8-1:0] pmem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata,
  input  logic                    pmem_resp
);
  arb_state_t state;
  logic d_req, pick_d, grant, done;
  assign d_req = data_mem_read | data_mem_write;
  assign grant = (state == IDLE) & (d_req | instr_mem_read);
  assign done  = (state != IDLE) & pmem_resp;
`ifdef MEM_ARB_RR_EN
  arb_grant_t last_grant;
  assign pick_d = d_req & (~instr_mem_read | (last_grant == GRANT_I));
  // remember who was served so a tie goes to the other port next time
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_grant <= GRANT_I;
    else if (grant) last_grant <= pick_d ? GRANT_D : GRANT_I;
`else
  assign pick_d = d_req;
`endif
  // one access in flight; every access passes back through IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else if (grant) state <= pick_d ? SERVE_D : SERVE_I;
    else if (done) state <= IDLE;
  mem_arb_req_reg #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_req (
    .clk           (clk),
    .rst           (rst),
    .load          (grant),
    .clr           (done),
    .address_d     (pick_d ? data_mem_address : instr_mem_address),
    .wdata_d       (pick_d ? data_mem_wdata : '0),
    .byte_enable_d (pick_d ? mem_byte_enable : '1),
    .read_d        (~pick_d | (data_mem_read & ~data_mem_write)),
    .write_d       (pick_d & data_mem_write),
    .address       (pmem_address),
    .wdata         (pmem_wdata),
    .byte_enable   (pmem_byte_enable),
    .read          (pmem_read),
    .write         (pmem_write)
  );
  assign instr_mem_resp  = (state == SERVE_I) & pmem_resp;
  assign data_mem_resp   = (state == SERVE_D) & pmem_resp;
  assign instr_mem_rdata = pmem_rdata;
  assign data_mem_rdata  = pmem_rdata;
  // a simultaneous load and store is served as a store; flag it
  assert property (@(posedge clk) disable iff (!rst) !(data_mem_read && data_mem_write));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-configurable memory model
module tb_mem_arbiter;
  logic        clk, rst;
  logic        instr_mem_read, instr_mem_resp;
  logic [31:0] instr_mem_address, instr_mem_rdata;
  logic        data_mem_read, data_mem_write, data_mem_resp;
  logic [31:0] data_mem_address, data_mem_wdata, data_mem_rdata;
  logic [3:0]  mem_byte_enable, pmem_byte_enable;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .instr_mem_read(instr_mem_read), .instr_mem_address(instr_mem_address),
    .instr_mem_rdata(instr_mem_rdata), .instr_mem_resp(instr_mem_resp),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
    .mem_byte_enable(mem_byte_enable), .data_mem_rdata(data_mem_rdata),
    .data_mem_resp(data_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {bit d; bit chk; logic [31:0] data;} exp_t;
  typedef struct {int c; logic rd; logic wr; logic [31:0] a; logic [31:0] wd; logic [3:0] be;} iss_t;
  exp_t sb[$];
  iss_t iq[$];
  exp_t mon_e;
  int total = 0, bad = 0, cyc = 0, lat = 1, wcnt = 0;
  int last_i_cyc = -1, last_d_cyc = -1;
  logic prev_st = 0;
  logic [31:0] prev_a, prev_wd;
  logic [3:0]  prev_be;
  logic prev_rd, prev_wr;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h60 ? 32'h13 : a ^ 32'h5A5A0000;
  endfunction
  assign pmem_rdata = mem_val(pmem_address);

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // memory: pmem_resp pulses once the strobe has been seen for more than lat cycles
  always @(posedge clk) begin
    #1;
    if (pmem_resp || !(pmem_read || pmem_write)) begin
      pmem_resp = 0;
      wcnt = 0;
    end else begin
      wcnt++;
      if (wcnt > lat) pmem_resp = 1;
    end
  end

  // monitor: scoreboard pops on resp, logs issued accesses, checks strobe stability
  always @(negedge clk) begin
    if (instr_mem_resp) last_i_cyc = cyc;
    if (data_mem_resp) last_d_cyc = cyc;
    if (instr_mem_resp || data_mem_resp) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got i=%0b d=%0b want none", instr_mem_resp, data_mem_resp);
      end else begin
        mon_e = sb.pop_front();
        if ((instr_mem_resp && data_mem_resp) || data_mem_resp != mon_e.d ||
            (mon_e.chk && (mon_e.d ? data_mem_rdata : instr_mem_rdata) !== mon_e.data)) begin
          bad++;
          $display("FAIL resp_check: got i=%0b d=%0b rdata=%h want d=%0b rdata=%h", instr_mem_resp,
                   data_mem_resp, mon_e.d ? data_mem_rdata : instr_mem_rdata, mon_e.d, mon_e.data);
        end
      end
    end
    if ((pmem_read || pmem_write) && !prev_st)
      iq.push_back('{cyc, pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable});
    if ((pmem_read || pmem_write) && prev_st) begin
      total++;
      if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable} !==
          {prev_rd, prev_wr, prev_a, prev_wd, prev_be}) begin
        bad++;
        $display("FAIL hold: got a=%h rd=%0b wr=%0b want a=%h rd=%0b wr=%0b", pmem_address,
                 pmem_read, pmem_write, prev_a, prev_rd, prev_wr);
      end
    end
    prev_st = pmem_read || pmem_write;
    {prev_rd, prev_wr, prev_a, prev_wd, prev_be} =
      {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pop_iss(output iss_t e);
    total++;
    if (iq.size() == 0) begin
      bad++;
      $display("FAIL issue_log: got empty want an access");
      e = '{-100, 0, 0, 0, 0, 0};
    end else e = iq.pop_front();
  endtask

  task automatic wait_resp(input bit d);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (d ? data_mem_resp : instr_mem_resp) break;
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL timeout: got no resp on port d=%0b want resp", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_req(input logic [31:0] a);
    instr_mem_address = a;
    instr_mem_read = 1;
    wait_resp(0);
    instr_mem_read = 0;
  endtask

  task automatic data_req(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    data_mem_address = a;
    data_mem_wdata = wd;
    mem_byte_enable = be;
    data_mem_read = !wr;
    data_mem_write = wr;
    wait_resp(1);
    data_mem_read = 0;
    data_mem_write = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    iss_t e;
    int c0;
    rst = 0;
    pmem_resp = 0;
    instr_mem_read = 0; instr_mem_address = 0;
    data_mem_read = 0; data_mem_write = 0; data_mem_address = 0;
    data_mem_wdata = 0; mem_byte_enable = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {pmem_read, pmem_write, instr_mem_resp, data_mem_resp}, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata_be", {pmem_wdata, pmem_byte_enable}, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;

    // fetch only
    lat = 1;
    c0 = cyc;
    sb.push_back('{0, 1, 32'h13});
    fetch_req(32'h60);
    pop_iss(e);
    chk("fetch_rise", e.c, c0 + 1);
    chk("fetch_fields", {e.rd, e.wr, e.be, e.wd, e.a}, {1'b1, 1'b0, 4'hF, 32'h0, 32'h60});
    chk("fetch_resp_cyc", last_i_cyc, c0 + 2);

    // simultaneous fetch and store: last grant was fetch, so the store wins either way
    sb.push_back('{1, 0, 32'h0});
    sb.push_back('{0, 1, 32'h5A5A0064});
    fork
      fetch_req(32'h64);
      data_req(1, 32'h1000, 32'hDEADBEEF, 4'b0011);
    join
    pop_iss(e);
    chk("store_fields", {e.rd, e.wr, e.be, e.wd, e.a}, {1'b0, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h1000});
    pop_iss(e);
    chk("fetch2_addr", {e.rd, e.a}, {1'b1, 32'h64});
    chk("fetch2_bubble", e.c, last_d_cyc + 2);

    // lone load makes data the last grant, then a tie
    sb.push_back('{1, 1, 32'h5A5A2000});
    data_req(0, 32'h2000, 0, 4'hF);
    pop_iss(e);
    chk("load_fields", {e.rd, e.wr, e.a}, {1'b1, 1'b0, 32'h2000});
`ifdef MEM_ARB_RR_EN
    sb.push_back('{0, 1, 32'h5A5A0068});
    sb.push_back('{1, 1, 32'h5A5A2004});
`else
    sb.push_back('{1, 1, 32'h5A5A2004});
    sb.push_back('{0, 1, 32'h5A5A0068});
`endif
    fork
      fetch_req(32'h68);
      data_req(0, 32'h2004, 0, 4'hF);
    join
    pop_iss(e);
`ifdef MEM_ARB_RR_EN
    chk("tie_first", e.a, 32'h68);
`else
    chk("tie_first", e.a, 32'h2004);
`endif
    pop_iss(e);

    // slow memory, request dropped after one cycle
    lat = 5;
    data_mem_address = 32'h3000;
    data_mem_read = 1;
    sb.push_back('{1, 1, 32'h5A5A3000});
    @(posedge clk); #1;
    data_mem_read = 0;
    data_mem_address = 32'hFFFF;
    wait_resp(1);
    pop_iss(e);
    chk("slow_addr", e.a, 32'h3000);
    chk("slow_len", last_d_cyc - e.c, 5);

    // reset in the middle of a store
    data_mem_address = 32'h4000;
    data_mem_wdata = 32'h12345678;
    mem_byte_enable = 4'hF;
    data_mem_write = 1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 0;
    data_mem_write = 0;
    #1;
    chk("rstmid_strobes", {pmem_read, pmem_write, instr_mem_resp, data_mem_resp}, 0);
    chk("rstmid_regs", {pmem_address, pmem_byte_enable}, 0);
    pop_iss(e);
    chk("rstmid_was_store", {e.wr, e.a}, {1'b1, 32'h4000});
    @(posedge clk); #1 rst = 1;
    lat = 1;
    @(posedge clk); #1;
    c0 = cyc;
    sb.push_back('{0, 1, 32'h5A5A0070});
    fetch_req(32'h70);
    pop_iss(e);
    chk("post_rst_rise", e.c, c0 + 1);
    chk("post_rst_addr", e.a, 32'h70);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("iq_empty", iq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
